// File: rtl/decode_stage_pipelined_if.sv
// Bus bundle for decode_stage_pipelined: IF/ID inputs, writeback port, pipeline
// control and the registered ID/EX outputs.
interface decode_stage_pipelined_if #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5
);
    logic              if_valid;
    logic [31:0]       if_instr;
    logic [XLEN-1:0]   if_pc;
    logic              wb_we;
    logic [REG_AW-1:0] wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              flush;
    logic              ex_hold;
    logic              stall_if;
    logic              ex_valid;
    logic [XLEN-1:0]   ex_pc;
    logic [XLEN-1:0]   ex_rs1_data;
    logic [XLEN-1:0]   ex_rs2_data;
    logic [XLEN-1:0]   ex_imm;
    logic [REG_AW-1:0] ex_rs1;
    logic [REG_AW-1:0] ex_rs2;
    logic [REG_AW-1:0] ex_rd;
    logic [2:0]        ex_funct3;
    logic              ex_funct7b5;
    logic              ex_branch;
    logic              ex_mem_read;
    logic              ex_mem_to_reg;
    logic              ex_mem_write;
    logic              ex_alu_src;
    logic              ex_reg_write;
    logic [1:0]        ex_alu_op;

    modport master (
        output if_valid, if_instr, if_pc, wb_we, wb_rd, wb_data, flush, ex_hold,
        input  stall_if, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5, ex_branch,
               ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src,
               ex_reg_write, ex_alu_op
    );

    modport slave (
        input  if_valid, if_instr, if_pc, wb_we, wb_rd, wb_data, flush, ex_hold,
        output stall_if, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5, ex_branch,
               ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src,
               ex_reg_write, ex_alu_op
    );
endinterface

// File: rtl/decode_stage_pipelined.sv
// Decode stage with register file, control/immediate decode, load-use stall and ID/EX register.
// Optional macro WB_BYPASS_EN: write-first register reads from the writeback port.
module decode_stage_pipelined #(
    parameter int  XLEN      = 64,
    parameter int  REG_COUNT = 32,
    localparam int REG_AW    = $clog2(REG_COUNT)
) (
    input  logic clk,
    input  logic rst,
    decode_stage_pipelined_if.slave bus
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef struct packed {
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [1:0] alu_op;
    } ctrl_t;

    logic [XLEN-1:0]   regs [REG_COUNT];
    logic [6:0]        opcode;
    logic [4:0]        rs1_f, rs2_f, rd_f;
    logic [REG_AW-1:0] rs1, rs2, rd;
    logic [XLEN-1:0]   rs1_data, rs2_data, imm;
    logic              use_rs1, use_rs2, hazard;
    ctrl_t             dec_ctrl, ex_ctrl;
    logic              unused_bits;

    assign opcode = bus.if_instr[6:0];
    assign rs1_f  = bus.if_instr[19:15];
    assign rs2_f  = bus.if_instr[24:20];
    assign rd_f   = bus.if_instr[11:7];
    // Smaller register files simply drop the upper index bits.
    assign rs1    = rs1_f[REG_AW-1:0];
    assign rs2    = rs2_f[REG_AW-1:0];
    assign rd     = rd_f[REG_AW-1:0];
    assign unused_bits = ^{rs1_f, rs2_f, rd_f};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else if (bus.wb_we && bus.wb_rd != '0) begin
            regs[bus.wb_rd] <= bus.wb_data;
        end
    end

    always_comb begin
        rs1_data = (rs1 == '0) ? '0 : regs[rs1];
        rs2_data = (rs2 == '0) ? '0 : regs[rs2];
`ifdef WB_BYPASS_EN
        if (bus.wb_we && bus.wb_rd != '0 && bus.wb_rd == rs1) rs1_data = bus.wb_data;
        if (bus.wb_we && bus.wb_rd != '0 && bus.wb_rd == rs2) rs2_data = bus.wb_data;
`endif
    end

    always_comb begin
        dec_ctrl = '0;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        imm      = '0;
        case (opcode)
            OP_R: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_op    = 2'b10;
                use_rs1            = 1'b1;
                use_rs2            = 1'b1;
            end
            OP_I: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.alu_op    = 2'b11;
                use_rs1            = 1'b1;
                imm = {{(XLEN-12){bus.if_instr[31]}}, bus.if_instr[31:20]};
            end
            OP_LOAD: begin
                dec_ctrl.mem_read   = 1'b1;
                dec_ctrl.mem_to_reg = 1'b1;
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.alu_src    = 1'b1;
                use_rs1             = 1'b1;
                imm = {{(XLEN-12){bus.if_instr[31]}}, bus.if_instr[31:20]};
            end
            OP_STORE: begin
                dec_ctrl.mem_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                use_rs1            = 1'b1;
                use_rs2            = 1'b1;
                imm = {{(XLEN-12){bus.if_instr[31]}}, bus.if_instr[31:25], bus.if_instr[11:7]};
            end
            OP_BRANCH: begin
                dec_ctrl.branch = 1'b1;
                dec_ctrl.alu_op = 2'b01;
                use_rs1         = 1'b1;
                use_rs2         = 1'b1;
                imm = {{(XLEN-13){bus.if_instr[31]}}, bus.if_instr[31], bus.if_instr[7],
                       bus.if_instr[30:25], bus.if_instr[11:8], 1'b0};
            end
            default: ;
        endcase
    end

    assign hazard = bus.ex_valid && ex_ctrl.mem_read && (bus.ex_rd != '0) && bus.if_valid &&
                    ((use_rs1 && rs1 == bus.ex_rd) || (use_rs2 && rs2 == bus.ex_rd));
    assign bus.stall_if = (hazard || bus.ex_hold) && !bus.flush;

    // Bubbles only clear valid and controls; operand fields keep stale values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.ex_valid    <= 1'b0;
            ex_ctrl         <= '0;
            bus.ex_pc       <= '0;
            bus.ex_rs1_data <= '0;
            bus.ex_rs2_data <= '0;
            bus.ex_imm      <= '0;
            bus.ex_rs1      <= '0;
            bus.ex_rs2      <= '0;
            bus.ex_rd       <= '0;
            bus.ex_funct3   <= '0;
            bus.ex_funct7b5 <= 1'b0;
        end else if (bus.flush || (!bus.ex_hold && hazard)) begin
            bus.ex_valid <= 1'b0;
            ex_ctrl      <= '0;
        end else if (!bus.ex_hold) begin
            bus.ex_valid    <= bus.if_valid;
            ex_ctrl         <= bus.if_valid ? dec_ctrl : '0;
            bus.ex_pc       <= bus.if_pc;
            bus.ex_rs1_data <= rs1_data;
            bus.ex_rs2_data <= rs2_data;
            bus.ex_imm      <= imm;
            bus.ex_rs1      <= rs1;
            bus.ex_rs2      <= rs2;
            bus.ex_rd       <= rd;
            bus.ex_funct3   <= bus.if_instr[14:12];
            bus.ex_funct7b5 <= bus.if_instr[30];
        end
    end

    assign bus.ex_branch     = ex_ctrl.branch;
    assign bus.ex_mem_read   = ex_ctrl.mem_read;
    assign bus.ex_mem_to_reg = ex_ctrl.mem_to_reg;
    assign bus.ex_mem_write  = ex_ctrl.mem_write;
    assign bus.ex_alu_src    = ex_ctrl.alu_src;
    assign bus.ex_reg_write  = ex_ctrl.reg_write;
    assign bus.ex_alu_op     = ex_ctrl.alu_op;
endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Self-checking bench: decode vector table with scoreboard, load-use, hold, flush,
// same-cycle writeback and reset sequences on a 64/32 and a 32/16 instance.
module tb_decode_stage_pipelined;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    decode_stage_pipelined_if #(.XLEN(64), .REG_AW(5)) bus ();
    decode_stage_pipelined_if #(.XLEN(32), .REG_AW(4)) sb ();

    decode_stage_pipelined #(.XLEN(64), .REG_COUNT(32)) dut (.clk(clk), .rst(rst), .bus(bus));
    decode_stage_pipelined #(.XLEN(32), .REG_COUNT(16)) dut_s (.clk(clk), .rst(rst), .bus(sb));

`ifdef WB_BYPASS_EN
    localparam logic [63:0] BYP_EXP = 64'h55;
`else
    localparam logic [63:0] BYP_EXP = 64'h11;
`endif
    localparam logic [31:0] LD_X2   = 32'h0000B103;  // ld x2,0(x1)
    localparam logic [31:0] ADD_X4  = 32'h00010233;  // add x4,x2,x0
    localparam logic [31:0] ADDI_X8 = 32'h00138413;  // addi x8,x7,1

    typedef struct {
        logic        valid;
        logic [31:0] instr;
        logic [7:0]  ctrl;
        logic [63:0] imm;
        logic [63:0] rs1d;
        logic [63:0] rs2d;
    } vec_t;

    vec_t vt[9];
    vec_t sbq[$];
    vec_t e;
    int total = 0;
    int bad = 0;
    int stalls, bubbles;
    logic s;
    logic [63:0] pc_hold;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] ctrl_of();
        return {bus.ex_branch, bus.ex_mem_read, bus.ex_mem_to_reg, bus.ex_mem_write,
                bus.ex_alu_src, bus.ex_reg_write, bus.ex_alu_op};
    endfunction

    task automatic wr(input logic [4:0] rd, input logic [63:0] d);
        @(negedge clk);
        bus.wb_we = 1'b1; bus.wb_rd = rd; bus.wb_data = d;
        @(posedge clk); #1;
        bus.wb_we = 1'b0;
    endtask

    initial begin
        vt[0] = '{1'b1, 32'h003180B3, 8'h06, 64'h0, 64'hDEADBEEF, 64'hDEADBEEF};
        vt[1] = '{1'b1, 32'hFFF00293, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0};
        vt[2] = '{1'b1, 32'h0080B103, 8'h6C, 64'h8, 64'h1000, 64'h0};
        vt[3] = '{1'b1, 32'h7E30BC23, 8'h18, 64'h7F8, 64'h1000, 64'hDEADBEEF};
        vt[4] = '{1'b1, 32'hFE208EE3, 8'h81, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1000, 64'h0};
        vt[5] = '{1'b1, 32'h0000007F, 8'h00, 64'h0, 64'h0, 64'h0};
        vt[6] = '{1'b1, 32'h12345037, 8'h00, 64'h0, 64'h0, 64'hDEADBEEF};
        vt[7] = '{1'b1, 32'h000000B3, 8'h06, 64'h0, 64'h0, 64'h0};
        vt[8] = '{1'b0, 32'h003180B3, 8'h00, 64'h0, 64'h0, 64'h0};

        bus.if_valid = 0; bus.if_instr = 0; bus.if_pc = 0; bus.wb_we = 0;
        bus.wb_rd = 0; bus.wb_data = 0; bus.flush = 0; bus.ex_hold = 0;
        sb.if_valid = 0; sb.if_instr = 0; sb.if_pc = 0; sb.wb_we = 0;
        sb.wb_rd = 0; sb.wb_data = 0; sb.flush = 0; sb.ex_hold = 0;

        #1;
        chk("reset_valid", {63'b0, bus.ex_valid}, 64'h0);
        chk("reset_ctrl", {56'b0, ctrl_of()}, 64'h0);
        chk("reset_stall", {63'b0, bus.stall_if}, 64'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        wr(5'd1, 64'h1000);
        wr(5'd3, 64'hDEADBEEF);
        wr(5'd5, 64'h1234);
        wr(5'd7, 64'h11);
        wr(5'd0, 64'hFF);

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            bus.if_valid = vt[i].valid;
            bus.if_instr = vt[i].instr;
            bus.if_pc    = 64'h100 + 64'(i * 4);
            sbq.push_back(vt[i]);
            @(posedge clk); #1;
            e = sbq.pop_front();
            chk($sformatf("v%0d_valid", i), {63'b0, bus.ex_valid}, {63'b0, e.valid});
            chk($sformatf("v%0d_ctrl", i), {56'b0, ctrl_of()}, {56'b0, e.ctrl});
            if (e.valid) begin
                chk($sformatf("v%0d_imm", i), bus.ex_imm, e.imm);
                chk($sformatf("v%0d_rs1d", i), bus.ex_rs1_data, e.rs1d);
                chk($sformatf("v%0d_rs2d", i), bus.ex_rs2_data, e.rs2d);
                chk($sformatf("v%0d_pc", i), bus.ex_pc, 64'h100 + 64'(i * 4));
            end
        end

        // load-use: one stall cycle, one bubble, then the dependent add
        @(negedge clk);
        bus.if_valid = 1'b1; bus.if_instr = LD_X2; bus.if_pc = 64'h200;
        @(posedge clk); #1;
        stalls = 0; bubbles = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.if_instr = ADD_X4; bus.if_pc = 64'h204;
            #1; s = bus.stall_if;
            @(posedge clk); #1;
            if (!s) break;
            stalls++;
            if (!bus.ex_valid && ctrl_of() == 8'h00) bubbles++;
        end
        chk("lu_stalls", 64'(stalls), 64'd1);
        chk("lu_bubbles", 64'(bubbles), 64'd1);
        chk("lu_add_valid", {63'b0, bus.ex_valid}, 64'h1);
        chk("lu_add_ctrl", {56'b0, ctrl_of()}, 64'h06);
        chk("lu_add_rs1", {59'b0, bus.ex_rs1}, 64'd2);

        // hold freezes ID/EX and stalls IF
        pc_hold = bus.ex_pc;
        @(negedge clk);
        bus.ex_hold = 1'b1; bus.if_instr = 32'hFFF00293; bus.if_pc = 64'h300;
        #1; chk("hold_stall", {63'b0, bus.stall_if}, 64'h1);
        @(posedge clk); #1;
        chk("hold_valid", {63'b0, bus.ex_valid}, 64'h1);
        chk("hold_ctrl", {56'b0, ctrl_of()}, 64'h06);
        chk("hold_pc", bus.ex_pc, pc_hold);
        @(negedge clk);
        bus.ex_hold = 1'b0; bus.if_instr = LD_X2; bus.if_pc = 64'h400;

        // flush beats both hazard and hold
        @(posedge clk); #1;
        chk("fl_ld_ctrl", {56'b0, ctrl_of()}, 64'h6C);
        @(negedge clk);
        bus.if_instr = ADD_X4; bus.flush = 1'b1; bus.ex_hold = 1'b1;
        #1; chk("fl_stall", {63'b0, bus.stall_if}, 64'h0);
        @(posedge clk); #1;
        chk("fl_valid", {63'b0, bus.ex_valid}, 64'h0);
        chk("fl_ctrl", {56'b0, ctrl_of()}, 64'h0);
        @(negedge clk);
        bus.flush = 1'b0; bus.ex_hold = 1'b0;

        // same-cycle writeback of x7 while decoding addi x8,x7,1
        bus.if_instr = ADDI_X8; bus.wb_we = 1'b1; bus.wb_rd = 5'd7; bus.wb_data = 64'h55;
        @(posedge clk); #1;
        chk("byp_rs1d", bus.ex_rs1_data, BYP_EXP);
        chk("byp_imm", bus.ex_imm, 64'h1);
        bus.wb_we = 1'b0;
        @(posedge clk); #1;
        chk("byp_next_rs1d", bus.ex_rs1_data, 64'h55);

        // same on the narrow 32-bit / 16-register instance
        @(negedge clk);
        sb.wb_we = 1'b1; sb.wb_rd = 4'd7; sb.wb_data = 32'h11;
        @(negedge clk);
        sb.wb_data = 32'h55; sb.if_valid = 1'b1; sb.if_instr = ADDI_X8;
        @(posedge clk); #1;
        chk("s_byp_rs1d", {32'b0, sb.ex_rs1_data}, BYP_EXP);
        chk("s_byp_ctrl", {63'b0, sb.ex_reg_write}, 64'h1);
        sb.wb_we = 1'b0;
        @(posedge clk); #1;
        chk("s_byp_next_rs1d", {32'b0, sb.ex_rs1_data}, 64'h55);

        // asynchronous reset mid-stream with a valid ID/EX slot
        @(negedge clk);
        bus.if_instr = 32'hFFF00293;
        @(posedge clk); #1;
        chk("pre_rst_valid", {63'b0, bus.ex_valid}, 64'h1);
        #2 rst = 1'b0;
        #1;
        chk("rst_valid", {63'b0, bus.ex_valid}, 64'h0);
        chk("rst_ctrl", {56'b0, ctrl_of()}, 64'h0);
        chk("rst_stall", {63'b0, bus.stall_if}, 64'h0);
        chk("rst_s_valid", {63'b0, sb.ex_valid}, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        bus.if_instr = 32'h005280B3;  // add x1,x5,x5
        @(posedge clk); #1;
        chk("rst_x5", bus.ex_rs1_data, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
